booth_ctrl: RTL and testbench
=============================

BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 4, meaning iteration-counter width; iterations per multiply N = 2**CNT_WIDTH (16 at default).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start_valid  input  1  operands present on datapath inputs.
REQ-005 The block SHALL have port start_ready  output  1  controller idle, will accept a start.
REQ-006 The block SHALL have port q0  input  1  multiplier-register LSB from datapath.
REQ-007 The block SHALL have port q_1  input  1  Booth Q-1 bit from datapath.
REQ-008 The block SHALL have port load  output  1  load M, Q and clear A, Q-1 in datapath.
REQ-009 The block SHALL have ports add_en and sub_en  output  1 each  A <= A+M and A <= A-M respectively.
REQ-010 The block SHALL have port shift_en  output  1  arithmetic right shift of {A,Q,Q-1}.
REQ-011 The block SHALL have port count  output  CNT_WIDTH  current iteration index.
REQ-012 The block SHALL have ports done_valid  output  1  product valid, and done_ready  input  1  consumer takes product.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, LOAD, EXEC, SHIFT, DONE.
REQ-015 In IDLE the block SHALL drive start_ready=1 and SHALL go to LOAD on the edge where start_valid=1, with count <= 0.
REQ-016 In LOAD the block SHALL assert load for exactly one cycle, then go to EXEC.
REQ-017 In EXEC the block SHALL sample {q0,q_1}: 10 -> sub_en=1, 01 -> add_en=1, 00/11 -> neither; next state SHALL be SHIFT.
REQ-018 In SHIFT the block SHALL assert shift_en; if count == N-1 it SHALL go to DONE, else count <= count+1 and go to EXEC.
REQ-019 Terminal detection SHALL be a combinational equality on count, with no extra pipeline cycle.
REQ-020 At most one of load/add_en/sub_en/shift_en SHALL be high in any cycle; all SHALL be low in IDLE and DONE.
REQ-021 done_valid SHALL rise exactly 2*N+1 cycles after the accepting edge (33 at default).
REQ-022 In DONE, done_valid SHALL hold at 1 until sampled with done_ready=1, then the FSM SHALL go to IDLE.
REQ-023 start_valid outside IDLE SHALL be ignored (start_ready=0); the earliest next accept SHALL be the first IDLE cycle after the DONE handshake.
REQ-024 count SHALL hold its value in DONE and SHALL never wrap during an operation.

Reset
REQ-025 On a rising edge with reset=1 the FSM SHALL enter IDLE and clear count, with priority over all other inputs.
REQ-026 While in reset, or in the cycle after it, the outputs SHALL be: start_ready=1, busy=0, done_valid=0, load/add_en/sub_en/shift_en=0, count=0.
REQ-027 Reset asserted mid-operation (any state) SHALL abandon the operation with no done_valid pulse.

Configuration
REQ-028 When macro BOOTH_CTRL_ABORT_EN is defined, the block SHALL add port abort (input, 1), and abort=1 at a rising edge in LOAD/EXEC/SHIFT SHALL force IDLE with count cleared and no done_valid.
REQ-029 When BOOTH_CTRL_ABORT_EN is defined, abort in IDLE or DONE SHALL have no effect, and reset SHALL override abort.
REQ-030 When BOOTH_CTRL_ABORT_EN is not defined, the block SHALL have no abort port and SHALL behave as REQ-014..027.

Verification
REQ-031 The bench SHALL cover: start_valid pulse in IDLE, q0=q_1=0 throughout -> load at cycle 1, 16 shift_en pulses, no add/sub, done_valid at cycle 33.
REQ-032 The bench SHALL cover: datapath M=3, Q=-5 driving q0/q_1 -> sub/add sequence per Booth encoding, product 0xFFFFFFF1 (-15) at done_valid.
REQ-033 The bench SHALL cover: done_ready held 0 for 10 cycles after done_valid -> done_valid stays 1, start_valid ignored, IDLE one cycle after done_ready=1.
REQ-034 The bench SHALL cover: reset=1 while count=7 in EXEC -> next cycle IDLE, count=0, all strobes 0, no done_valid.
REQ-035 The bench SHALL cover: back-to-back starts with start_valid tied 1 and done_ready tied 1 -> accepts spaced exactly 35 cycles apart.
REQ-036 The bench SHALL cover, with BOOTH_CTRL_ABORT_EN defined: abort at count=4 in SHIFT -> IDLE next cycle, start_ready=1, done_valid never asserted.

Source files
------------

// File: rtl/booth_ctrl.sv
// Control FSM for a radix-2 Booth multiplier: sequences load, add/sub and shift strobes
// for a separate datapath. Define BOOTH_CTRL_ABORT_EN to add the abort input.
module booth_ctrl #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef BOOTH_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 q0,
    input  logic                 q_1,
    output logic                 load,
    output logic                 add_en,
    output logic                 sub_en,
    output logic                 shift_en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EXEC  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // N-1 with N = 2**CNT_WIDTH is simply all ones
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        start_ready = 1'b0;
        load        = 1'b0;
        add_en      = 1'b0;
        sub_en      = 1'b0;
        shift_en    = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b1;

        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                case ({q0, q_1})
                    2'b10:   sub_en = 1'b1;
                    2'b01:   add_en = 1'b1;
                    default: ;
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (count_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_WIDTH'(1);
                    state_d = EXEC;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef BOOTH_CTRL_ABORT_EN
        if (abort && (state_q == LOAD || state_q == EXEC || state_q == SHIFT)) begin
            state_d = IDLE;
            count_d = '0;
        end
`endif

        // Outputs read as idle while reset is held, regardless of the registered state
        if (reset) begin
            start_ready = 1'b1;
            busy        = 1'b0;
            done_valid  = 1'b0;
            load        = 1'b0;
            add_en      = 1'b0;
            sub_en      = 1'b0;
            shift_en    = 1'b0;
        end
    end

    assign count = reset ? '0 : count_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Scoreboard bench for booth_ctrl: a behavioural Booth datapath drives q0/q_1 and the
// monitor checks product, strobe counts and latency at each done handshake.
module tb_booth_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic          q0, q_1;
    logic          load, add_en, sub_en, shift_en;
    logic [CW-1:0] count;
    logic          done_valid;
    logic          done_ready = 1'b1;
    logic          busy;
`ifdef BOOTH_CTRL_ABORT_EN
    logic          abort = 1'b0;
`endif

    booth_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef BOOTH_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .start_valid(start_valid),
        .start_ready(start_ready),
        .q0         (q0),
        .q_1        (q_1),
        .load       (load),
        .add_en     (add_en),
        .sub_en     (sub_en),
        .shift_en   (shift_en),
        .count      (count),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural datapath: {A,Q,Q-1} responding to the controller strobes
    logic [15:0] m_op = '0, q_op = '0;
    logic [15:0] dp_a = '0, dp_q = '0, dp_m = '0;
    logic        dp_q1 = 1'b0;
    always @(posedge clk) begin
        if (load) begin
            dp_a  <= '0;
            dp_q  <= q_op;
            dp_m  <= m_op;
            dp_q1 <= 1'b0;
        end else if (add_en) begin
            dp_a <= dp_a + dp_m;
        end else if (sub_en) begin
            dp_a <= dp_a - dp_m;
        end else if (shift_en) begin
            dp_a  <= {dp_a[15], dp_a[15:1]};
            dp_q  <= {dp_a[0], dp_q[15:1]};
            dp_q1 <= dp_q[0];
        end
    end
    assign q0  = dp_q[0];
    assign q_1 = dp_q1;

    typedef struct {
        logic [31:0] prod;
        int          adds;
        int          subs;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic b2b = 1'b0;
    int   n_acc = 0;

    // Monitor: samples on the falling edge, pops the scoreboard at each done handshake
    initial begin
        int   acc_edge = 0, prev_acc = 0, load_lat = -1, rise_lat = -1;
        int   n_add = 0, n_sub = 0, n_shf = 0;
        bit   have_prev = 0, dv_prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (start_valid && start_ready) begin
                    if (b2b && have_prev) chk("accept_spacing", 64'(cyc + 1 - prev_acc), 64'd35);
                    prev_acc  = cyc + 1;
                    have_prev = b2b;
                    acc_edge  = cyc + 1;
                    n_acc++;
                end
                if ((32'(load) + 32'(add_en) + 32'(sub_en) + 32'(shift_en)) > 1 ||
                    ((!busy || done_valid) && (load || add_en || sub_en || shift_en))) begin
                    checks++;
                    errors++;
                    $display("FAIL strobes: got l%b a%b s%b sh%b busy%b dv%b expected exclusive/idle-low",
                             load, add_en, sub_en, shift_en, busy, done_valid);
                end
                if (load) begin
                    load_lat = cyc - acc_edge;
                    n_add = 0; n_sub = 0; n_shf = 0;
                end
                if (add_en)   n_add++;
                if (sub_en)   n_sub++;
                if (shift_en) n_shf++;
                if (done_valid && !dv_prev) rise_lat = cyc - acc_edge;
                if (done_valid && done_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done_valid=1 expected no product");
                    end else begin
                        e = exp_q.pop_front();
                        chk("product", {dp_a, dp_q}, e.prod);
                        chk("add_count", 64'(n_add), 64'(e.adds));
                        chk("sub_count", 64'(n_sub), 64'(e.subs));
                        chk("shift_count", 64'(n_shf), 64'd16);
                        chk("load_latency", 64'(load_lat), 64'd0);
                        chk("done_latency", 64'(rise_lat), 64'd33);
                    end
                end
            end
            dv_prev = done_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) tick();
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic push(input logic [31:0] p, input int a, input int s);
        exp_t e;
        e.prod = p; e.adds = a; e.subs = s;
        exp_q.push_back(e);
    endtask

    task automatic run_op(input logic [15:0] m, input logic [15:0] q,
                          input logic [31:0] p, input int a, input int s);
        m_op = m; q_op = q;
        push(p, a, s);
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        wait_idle();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done_valid"}, 64'(done_valid), 64'd0);
        chk({tag, "_strobes"}, 64'({load, add_en, sub_en, shift_en}), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_idle_outputs("in_reset");
        reset = 1'b0;
        tick();
        chk_idle_outputs("after_reset");

        // q0=q_1=0 throughout: no add/sub, 16 shifts
        run_op(16'd0, 16'd0, 32'h0000_0000, 0, 0);
        // M=3, Q=-5 -> -15
        run_op(16'd3, 16'hFFFB, 32'hFFFF_FFF1, 1, 2);

        // Product held while done_ready is low; starts ignored
        done_ready = 1'b0;
        m_op = 16'd7; q_op = 16'd6;
        push(32'h0000_002A, 1, 1);
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 100 && !done_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            chk("hold_done_valid", 64'(done_valid), 64'd1);
            chk("hold_start_ready", 64'(start_ready), 64'd0);
            start_valid = 1'b1;
            tick();
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        tick();
        chk("post_hs_busy", 64'(busy), 64'd0);
        chk("post_hs_start_ready", 64'(start_ready), 64'd1);

        // Reset mid-operation in EXEC at count 7
        m_op = 16'd5; q_op = 16'd3;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 100 && !(busy && count == 4'd7 && !shift_en && !load); i++) tick();
        chk("reach_exec7", 64'(count), 64'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_outputs("mid_reset");
        for (int i = 0; i < 40; i++) tick();
        chk("mid_reset_no_done", 64'(busy), 64'd0);

        // Back-to-back: start_valid and done_ready tied high
        m_op = 16'hFFFE; q_op = 16'd9;
        for (int i = 0; i < 3; i++) push(32'hFFFF_FFEE, 2, 2);
        b2b = 1'b1;
        begin
            int base;
            base = n_acc;
            start_valid = 1'b1;
            for (int i = 0; i < 200 && n_acc < base + 3; i++) tick();
            start_valid = 1'b0;
            chk("b2b_accepts", 64'(n_acc - base), 64'd3);
        end
        wait_idle();
        b2b = 1'b0;

`ifdef BOOTH_CTRL_ABORT_EN
        // Abort in SHIFT at count 4
        m_op = 16'd5; q_op = 16'd3;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 100 && !(busy && count == 4'd4 && shift_en); i++) tick();
        chk("reach_shift4", 64'(shift_en), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle_outputs("abort");
        for (int i = 0; i < 40; i++) tick();
        chk("abort_no_done", 64'(busy), 64'd0);
`endif

        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
